// File: rtl/branch_predictor_btb_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_btb_pkg
//   Shared constants and types for the BTB branch predictor.
//   - Predictor mode codes (NOT_TAKEN, ALWAYS_TAKEN, SATURATION, HYSTERESIS)
//   - 2-bit counter type and its reset / allocation values
// ---------------------------------------------------------------------------
package branch_predictor_btb_pkg;

    localparam int BRANCH_NOT_TAKEN    = 0;
    localparam int BRANCH_ALWAYS_TAKEN = 1;
    localparam int BRANCH_SATURATION   = 2;
    localparam int BRANCH_HYSTERESIS   = 3;

    typedef logic [1:0] ctr_t;

    localparam ctr_t BP_CTR_RESET        = 2'b01;  // weakly not-taken
    localparam ctr_t BP_CTR_ALLOC_TAKEN  = 2'b10;  // new conditional entry
    localparam ctr_t BP_CTR_STRONG_TAKEN = 2'b11;  // jumps always land here

    // The counter MSB is the taken/not-taken prediction in both counter modes.
    function automatic logic ctr_predicts_taken(input ctr_t c);
        return c[1];
    endfunction

endpackage

// File: rtl/branch_predictor_btb_counter_update.sv
// ---------------------------------------------------------------------------
// bp_counter_update
//   Combinational next-state function for one 2-bit branch counter.
//   MODE = BRANCH_HYSTERESIS selects the hysteresis table; every other mode
//   uses the saturating up/down counter (the counter is still maintained in
//   the non-counter modes, it just is not consulted for prediction).
// Ports
//   i_ctr    in   2   current counter value
//   i_taken  in   1   resolved outcome
//   o_ctr    out  2   next counter value
// ---------------------------------------------------------------------------
module bp_counter_update
    import branch_predictor_btb_pkg::*;
#(
    parameter int MODE = BRANCH_SATURATION
) (
    input  ctr_t i_ctr,
    input  logic i_taken,
    output ctr_t o_ctr
);

    always_comb begin
        // NOTE: assign a default first so every path drives o_ctr and no latch is inferred.
        o_ctr = i_ctr;
        if (MODE == BRANCH_HYSTERESIS) begin
            // Strong states are entered directly from the weak side (01->11, 10->00).
            if (i_taken) o_ctr = (i_ctr == 2'b00) ? 2'b01 : 2'b11;
            else         o_ctr = (i_ctr == 2'b11) ? 2'b10 : 2'b00;
        end else begin
            if (i_taken) o_ctr = (i_ctr == 2'b11) ? 2'b11 : i_ctr + 2'b01;
            else         o_ctr = (i_ctr == 2'b00) ? 2'b00 : i_ctr - 2'b01;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// branch_predictor_btb
//   Direct-mapped branch target buffer with a 2-bit counter per entry.
//   IF looks up if_pc combinationally (zero latency) and gets the next fetch
//   PC; the resolving stage writes updates that are visible from the next
//   edge. A same-cycle lookup of the entry being updated sees old contents.
//   Optional feature macro: BP_STATS_EN enables branch / mispredict counters;
//   when undefined no counter flops exist and the stat outputs are tied to 0.
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   if_pc / pred_pc / pred_taken / btb_hit     fetch-side lookup
//   upd_valid, upd_pc, upd_target, upd_taken,
//   upd_is_jump, upd_pred_taken                resolve-side update
//   stat_branches, stat_mispredicts            saturating statistics
// ---------------------------------------------------------------------------
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int WORD_SIZE      = 16,
    parameter int BTB_INDEX_BITS = 8,
    parameter int PREDICTOR_MODE = BRANCH_ALWAYS_TAKEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] if_pc,
    output logic [WORD_SIZE-1:0] pred_pc,
    output logic                 pred_taken,
    output logic                 btb_hit,
    input  logic                 upd_valid,
    input  logic [WORD_SIZE-1:0] upd_pc,
    input  logic [WORD_SIZE-1:0] upd_target,
    input  logic                 upd_taken,
    input  logic                 upd_is_jump,
    input  logic                 upd_pred_taken,
    output logic [WORD_SIZE-1:0] stat_branches,
    output logic [WORD_SIZE-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << BTB_INDEX_BITS;
    localparam int TAG_W   = WORD_SIZE - BTB_INDEX_BITS;

    if (BTB_INDEX_BITS < 1 || BTB_INDEX_BITS > WORD_SIZE - 1) begin : g_bad_index
        $error("BTB_INDEX_BITS must be in 1..WORD_SIZE-1");
    end

    logic [ENTRIES-1:0]   r_valid;
    logic [TAG_W-1:0]     r_tag    [ENTRIES];
    logic [WORD_SIZE-1:0] r_target [ENTRIES];
    ctr_t                 r_ctr    [ENTRIES];

    // ---------------- lookup ----------------
    logic [BTB_INDEX_BITS-1:0] w_if_idx;
    logic [TAG_W-1:0]          w_if_tag;
    logic                      w_hit;
    logic                      w_pred_taken;

    assign w_if_idx = if_pc[BTB_INDEX_BITS-1:0];
    assign w_if_tag = if_pc[WORD_SIZE-1:BTB_INDEX_BITS];
    // Outputs are forced to "miss" while reset is held so fetch runs sequentially.
    assign w_hit    = !reset && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    always_comb begin
        w_pred_taken = 1'b0;
        case (PREDICTOR_MODE)
            BRANCH_ALWAYS_TAKEN: w_pred_taken = w_hit;
            BRANCH_SATURATION,
            BRANCH_HYSTERESIS:   w_pred_taken = w_hit && ctr_predicts_taken(r_ctr[w_if_idx]);
            default:             w_pred_taken = 1'b0;
        endcase
    end

    assign btb_hit    = w_hit;
    assign pred_taken = w_pred_taken;
    assign pred_pc    = w_pred_taken ? r_target[w_if_idx] : if_pc + WORD_SIZE'(1);

    // ---------------- update ----------------
    logic [BTB_INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_W-1:0]          w_upd_tag;
    logic                      w_upd_hit;
    logic                      w_upd_write;
    ctr_t                      w_ctr_next;

    assign w_upd_idx   = upd_pc[BTB_INDEX_BITS-1:0];
    assign w_upd_tag   = upd_pc[WORD_SIZE-1:BTB_INDEX_BITS];
    assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    // Hits always refresh the entry; misses allocate only when taken.
    assign w_upd_write = upd_valid && (w_upd_hit || upd_taken);

    bp_counter_update #(.MODE(PREDICTOR_MODE)) u_ctr_next (
        .i_ctr   (r_ctr[w_upd_idx]),
        .i_taken (upd_taken),
        .o_ctr   (w_ctr_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= BP_CTR_RESET;
        end else if (w_upd_write) begin
            r_valid[w_upd_idx] <= 1'b1;
            if (upd_is_jump)    r_ctr[w_upd_idx] <= BP_CTR_STRONG_TAKEN;
            else if (w_upd_hit) r_ctr[w_upd_idx] <= w_ctr_next;
            else                r_ctr[w_upd_idx] <= BP_CTR_ALLOC_TAKEN;
        end
    end

    // NOTE: tag/target arrays have no reset; valid bits gate them, so they can map to plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && w_upd_write) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target;
        end
    end

    // ---------------- statistics ----------------
`ifdef BP_STATS_EN
    logic [WORD_SIZE-1:0] r_stat_branches;
    logic [WORD_SIZE-1:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (upd_valid && !upd_is_jump) begin
            if (r_stat_branches != '1) r_stat_branches <= r_stat_branches + WORD_SIZE'(1);
            if ((upd_taken != upd_pred_taken) && (r_stat_mispredicts != '1))
                r_stat_mispredicts <= r_stat_mispredicts + WORD_SIZE'(1);
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    logic w_unused_stats;
    assign w_unused_stats   = upd_pred_taken;
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
